// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front-end.
// Holds the FSM states, vote positions and baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } rx_state_t;

    localparam int unsigned OS_RATE = 16;

    localparam logic [3:0] SAMPLE_FIRST = 4'd7;
    localparam logic [3:0] SAMPLE_MID   = 4'd8;
    localparam logic [3:0] SAMPLE_LAST  = 4'd9;
    localparam logic [3:0] SCNT_LAST    = 4'd15;

    function automatic int unsigned baud_div(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        int unsigned d;
        d = clk_hz / (baud * OS_RATE);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic majority3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// Head byte reads as zero while the FIFO is empty.
module rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rx_fifo: DEPTH must be a power of two >= 2");
    end

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? 8'h00 : mem[rptr[AW-1:0]];

    // Advance the pointers; they wrap naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampling 8N1 UART receiver with majority vote, sticky error
// flags and a small FWFT receive FIFO.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       en,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);

    if (OVERSAMPLE != OS_RATE) begin : g_bad_os
        $error("uart_rx_frontend: only 16x oversampling is supported");
    end

    logic        rxd_m;
    logic        rxd_s;
    logic [31:0] div_cnt;
    logic        tick;
    rx_state_t   state;
    logic [3:0]  scnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        v_first;
    logic        v_mid;
    logic        vote;
    logic        stop_tick;
    logic        push;
    logic        stop_bad;
    logic        full;
    logic        empty;

    // Two-flop synchroniser; idle-high line resets to 1.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign tick = (div_cnt == DIV - 1);

    // Free-running oversample tick divider.
    always_ff @(posedge sysclk) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 32'd1;
    end

    assign vote      = majority3(v_first, v_mid, rxd_s);
    assign stop_tick = tick && (state == STOP) && (scnt == SAMPLE_LAST);
    assign push      = stop_tick && vote;
    assign stop_bad  = stop_tick && !vote;

    // Receive FSM; every transition is qualified by the tick.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state   <= IDLE;
            scnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            v_first <= 1'b0;
            v_mid   <= 1'b0;
        end else if (tick) begin
            if (state != IDLE)        scnt    <= scnt + 4'd1;
            if (scnt == SAMPLE_FIRST) v_first <= rxd_s;
            if (scnt == SAMPLE_MID)   v_mid   <= rxd_s;
            case (state)
                IDLE: begin
                    if (en && !rxd_s) begin
                        state <= START;
                        scnt  <= '0;
                    end
                end
                START: begin
                    if (scnt == SAMPLE_FIRST && rxd_s) begin
                        state <= IDLE;
                    end else if (scnt == SCNT_LAST) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (scnt == SAMPLE_LAST) shreg <= {vote, shreg[7:1]};
                    if (scnt == SCNT_LAST) begin
                        if (bit_idx == 3'd7) state   <= STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (scnt == SAMPLE_LAST) state <= vote ? IDLE : BRK_WAIT;
                end
                BRK_WAIT: begin
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a set in the clearing cycle wins.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (stop_bad)                 frame_err <= 1'b1;
            if (push && full && !rd_en)   overrun   <= 1'b1;
        end
    end

    rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .reset (reset),
        .push  (push),
        .wdata (shreg),
        .pop   (rd_en),
        .rdata (rd_data),
        .full  (full),
        .empty (empty)
    );

    assign rd_valid = !empty;
    assign busy     = (state != IDLE);

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Oversampling UART receive front-end with a small receive FIFO. It sits directly upstream of the memory-mapped peripheral's receive-data register. Its job is to turn the raw `rxd` pin into framed, validated bytes plus error flags. The peripheral pops bytes on a CPU read and reports status bits.

## Interface
- `CLK_HZ`, 50_000_000: `sysclk` frequency in Hz.
- `BAUD`, 9600: line baud rate.
- `OVERSAMPLE`, 16: ticks per bit. Fixed at 16; other values are unsupported.
- `FIFO_DEPTH`, 4: receive FIFO entries. Must be a power of two, ≥2.
- `sysclk  input  1  system clock`
- `reset  input  1  synchronous, active-high reset`
- `rxd  input  1  asynchronous serial line, idle high`
- `en  input  1  receiver enable; gates start-bit detection only`
- `rd_en  input  1  pop one byte from the FIFO head`
- `err_clr  input  1  clear frame_err and overrun`
- `rd_data  output  8  FIFO head byte (first-word fall-through); 8'h00 when empty`
- `rd_valid  output  1  FIFO not empty`
- `busy  output  1  frame in progress (state ≠ IDLE)`
- `frame_err  output  1  sticky: stop bit sampled low`
- `overrun  output  1  sticky: byte dropped because FIFO full`

Clock is `sysclk` and reset is `reset`. There is one clock. Reset is synchronous and active-high.

## Operation
- **Synchroniser:** `rxd` passes through 2 flops to give `rxd_s`. Both flops reset to 1.
- **Tick divider:** DIV = max(1, CLK_HZ / (BAUD·16)), using integer division (50 MHz / 9600 gives 325). The counter is free-running. `tick` asserts for one cycle when count == DIV-1, then the count wraps to 0.
- **Sample counter:** `scnt` is 4 bits. It increments on each `tick` while not IDLE and wraps 15→0.
- **Majority vote:** the bit value is the majority of `rxd_s` at scnt 7, 8 and 9. It is evaluated at scnt==9.
- **FSM.** All transitions happen on `tick` only.
  - IDLE: if `en && !rxd_s`, go to START with scnt=0.
  - START: at scnt==7, if `rxd_s`==1 it is a glitch, so go to IDLE. Otherwise, at scnt==15 go to DATA with bit index 0.
  - DATA: shift the voted bit into the shift register, LSB first, at scnt==9. At scnt==15, advance the bit index. After bit 7, go to STOP.
  - STOP: vote at scnt==9.
    - Vote 1: push the byte and go to IDLE.
    - Vote 0: set `frame_err`, discard the byte, and go to BRK_WAIT.
  - BRK_WAIT: go to IDLE when `rxd_s`==1.
- **Enable:** deasserting `en` mid-frame does not abort the frame; it completes normally.
- **FIFO:** wr/rd pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full means the MSBs differ and the LSBs are equal.
  - `rd_en` while empty: ignored.
  - Push while full with no simultaneous pop: byte dropped and `overrun` set.
  - Push and pop in the same cycle while full: both succeed and `overrun` is not set.
- **Sticky flags:** `err_clr` clears both flags. If a set event and `err_clr` occur in the same cycle, the set wins.

## Timing
- **Reset values:** `rd_data`=0, `rd_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0.
  - FSM resets to IDLE; pointers, `scnt` and divider reset to 0.
  - A reset mid-frame takes effect on the next edge, with no partial push.
- **Receive latency:** `rd_valid` and the new `rd_data` are visible 1 cycle after the STOP scnt==9 tick. That is about 9.5 bit times plus 2–3 cycles after the start edge.
- **Pop:** on the cycle after `rd_en`, `rd_data` shows the next entry (or 0) and `rd_valid` updates.
- **`busy`:** rises 1 cycle after the detecting tick. It falls 1 cycle after the tick that enters IDLE.
- **Flags:** `frame_err` and `overrun` rise 1 cycle after the STOP vote tick.

## Structure
- **Package `uart_pkg`:** holds
  - the state enum (IDLE, START, DATA, STOP, BRK_WAIT);
  - the OVERSAMPLE=16 constant;
  - the vote sample indices 7/8/9;
  - a `baud_div(clk_hz, baud)` constant function.
- **Sub-module `rx_fifo`:** a generic synchronous FWFT FIFO (width 8, depth parameter) exposing `push`, `pop`, `full` and `empty`. The FSM, divider and flags stay in the top level.

## Test plan
All scenarios use CLK_HZ=1600 and BAUD=100, so DIV=1 and one bit is 16 cycles.
1. **Clean byte:** send 0xA5 8N1, with a 1-cycle low glitch inside bit 2 at scnt 8 only. Expect `rd_valid`=1, `rd_data`=0xA5, `frame_err`=0, and `busy` low after the stop bit.
2. **Start glitch:** `rxd` low for 4 cycles, then high. Expect no push, `busy` back to 0 within 8 cycles, and `rd_valid`=0.
3. **Framing error:** send 0x3C with stop bit 0, holding the line low 40 more cycles. Expect no push, `frame_err`=1, and `busy`=1 until `rxd` goes high. Then pulse `err_clr`; expect `frame_err`=0.
4. **Overrun:** send 0x01..0x05 back to back with no reads. Expect `overrun`=1. Four pops return 01, 02, 03, 04, then `rd_valid`=0.
   - Variant: pop on the same cycle as the 5th push. Expect `overrun`=0 and entries 02..05.
5. **Reset mid-frame:** assert `reset` during bit 3. Expect all outputs at reset values on the next cycle. A following 0x5A is received correctly.
6. **Enable gating:**
   - `en`=0 during a start bit: frame ignored.
   - `en` dropped during bit 4 of 0xC3: 0xC3 is still pushed.
